// File: rtl/minirisc_timer_pkg.sv
// Register map, control/status bit positions and prescaler encoding shared by the timer files.
package minirisc_timer_pkg;

  typedef enum logic [1:0] {
    OFF_TR  = 2'd0,
    OFF_TC  = 2'd1,
    OFF_TS  = 2'd2,
    OFF_RSV = 2'd3
  } reg_off_e;

  localparam int TC_ENA   = 0;
  localparam int TC_REP   = 1;
  localparam int TC_IE    = 2;
  localparam int TC_PS_LO = 4;
  localparam int TC_PS_HI = 6;
  localparam int TS_TOUT  = 0;
  localparam int TS_ENA   = 1;

  typedef enum logic [2:0] {
    PS_DIV1     = 3'd0,
    PS_DIV16    = 3'd1,
    PS_DIV64    = 3'd2,
    PS_DIV256   = 3'd3,
    PS_DIV1K    = 3'd4,
    PS_DIV4K    = 3'd5,
    PS_DIV16K   = 3'd6,
    PS_DIV64K   = 3'd7
  } ps_e;

  // Terminal PCNT value (DIV-1) for each prescaler select.
  function automatic logic [15:0] ps_div_m1(input logic [2:0] ps);
    logic [15:0] w_lim;
    w_lim = 16'd0;
    case (ps_e'(ps))
      PS_DIV1:   w_lim = 16'd0;
      PS_DIV16:  w_lim = 16'd15;
      PS_DIV64:  w_lim = 16'd63;
      PS_DIV256: w_lim = 16'd255;
      PS_DIV1K:  w_lim = 16'd1023;
      PS_DIV4K:  w_lim = 16'd4095;
      PS_DIV16K: w_lim = 16'd16383;
      PS_DIV64K: w_lim = 16'hFFFF;
      default:   w_lim = 16'd0;
    endcase
    return w_lim;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: PCNT counts enabled cycles and emits a one-cycle tick every DIV of them.
// tick is combinational from PCNT/ena; clr restarts the count at the next edge.
module timer_prescaler
  import minirisc_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clr,
  input  logic [2:0] ps,
  output logic       tick
);

  logic [15:0] r_pcnt;
  logic        w_last;

  assign w_last = (r_pcnt == ps_div_m1(ps));
  assign tick   = ena & w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
    end else if (clr || tick) begin
      r_pcnt <= '0;
    end else if (ena) begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/minirisc_timer.sv
// MiniRISC bus timer: 8-bit reloadable down-counter with prescaler and clear-on-read timeout.
// Writes land on the wr edge, reads are zero-latency combinational; the bus is never stalled.
module minirisc_timer
  import minirisc_timer_pkg::*;
#(
  parameter logic [7:0] BASEADDR = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_mst2slv_addr,
  input  logic       s_mst2slv_wr,
  input  logic       s_mst2slv_rd,
  input  logic [7:0] s_mst2slv_data,
  output logic [7:0] s_slv2mst_data,
  output logic       irq
);

  logic [7:0] r_limit;
  logic [7:0] r_cnt;
  logic       r_ena;
  logic       r_rep;
  logic       r_ie;
  logic [2:0] r_ps;
  logic       r_tout;

  logic       w_sel;
  reg_off_e   w_off;
  logic       w_wr_tr;
  logic       w_wr_tc;
  logic       w_rd_ts;
  logic       w_tick;
  logic       w_tick_eff;
  logic       w_tmo;

  assign w_sel   = (s_mst2slv_addr[7:2] == BASEADDR[7:2]);
  assign w_off   = reg_off_e'(s_mst2slv_addr[1:0]);
  assign w_wr_tr = s_mst2slv_wr & w_sel & (w_off == OFF_TR);
  assign w_wr_tc = s_mst2slv_wr & w_sel & (w_off == OFF_TC);
  // A simultaneous wr turns the transfer into a write, so it must not clear TOUT.
  assign w_rd_ts = s_mst2slv_rd & ~s_mst2slv_wr & w_sel & (w_off == OFF_TS);

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .ena  (r_ena),
    .clr  (w_wr_tr | w_wr_tc),
    .ps   (r_ps),
    .tick (w_tick)
  );

  // Register writes override a coincident tick: no decrement, no timeout.
  assign w_tick_eff = w_tick & ~w_wr_tr & ~w_wr_tc;
  assign w_tmo      = w_tick_eff & (r_cnt == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_limit <= '0;
      r_cnt   <= '0;
    end else if (w_wr_tr) begin
      r_limit <= s_mst2slv_data;
      r_cnt   <= s_mst2slv_data;
    end else if (w_tmo) begin
      if (r_rep) r_cnt <= r_limit;
    end else if (w_tick_eff) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ena <= 1'b0;
      r_rep <= 1'b0;
      r_ie  <= 1'b0;
      r_ps  <= '0;
    end else if (w_wr_tc) begin
      r_ena <= s_mst2slv_data[TC_ENA];
      r_rep <= s_mst2slv_data[TC_REP];
      r_ie  <= s_mst2slv_data[TC_IE];
      r_ps  <= s_mst2slv_data[TC_PS_HI:TC_PS_LO];
    end else if (w_tmo && !r_rep) begin
      r_ena <= 1'b0;
    end
  end

  // Set beats clear-on-read so a timeout coinciding with a TS read is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tout <= 1'b0;
    end else if (w_wr_tr) begin
      r_tout <= 1'b0;
    end else if (w_tmo) begin
      r_tout <= 1'b1;
    end else if (w_rd_ts) begin
      r_tout <= 1'b0;
    end
  end

  always_comb begin
    s_slv2mst_data = '0;
    if (s_mst2slv_rd && w_sel) begin
      case (w_off)
        OFF_TR: s_slv2mst_data = r_cnt;
        OFF_TC: begin
          s_slv2mst_data[TC_ENA]            = r_ena;
          s_slv2mst_data[TC_REP]            = r_rep;
          s_slv2mst_data[TC_IE]             = r_ie;
          s_slv2mst_data[TC_PS_HI:TC_PS_LO] = r_ps;
        end
        OFF_TS: begin
          s_slv2mst_data[TS_TOUT] = r_tout;
          s_slv2mst_data[TS_ENA]  = r_ena;
        end
        default: s_slv2mst_data = '0;
      endcase
    end
  end

  assign irq = r_tout & r_ie;

endmodule

// File: tb/tb_minirisc_timer.sv
// Bench for minirisc_timer: directed bus traffic, a behavioural timer model and literal checkpoints.
module tb_minirisc_timer;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdat;
  logic [7:0] rdat;
  logic       irq;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  minirisc_timer #(.BASEADDR(8'h80)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_mst2slv_addr (addr),
    .s_mst2slv_wr   (wr),
    .s_mst2slv_rd   (rd),
    .s_mst2slv_data (wdat),
    .s_slv2mst_data (rdat),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: counter value, reload value, control bits, timeout flag and
  // the number of enabled cycles seen since the prescaler was last restarted.
  int m_limit = 0;
  int m_cnt   = 0;
  int m_ps    = 0;
  int m_phase = 0;
  bit m_ena   = 1'b0;
  bit m_rep   = 1'b0;
  bit m_ie    = 1'b0;
  bit m_tout  = 1'b0;

  function automatic int div_of(input int ps);
    return (ps == 0) ? 1 : (4 ** (ps + 1));
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [7:0] a, input logic r);
    logic [7:0] v;
    v = 8'h00;
    if (r && a >= 8'h80 && a <= 8'h83) begin
      if (a == 8'h80) v = m_cnt[7:0];
      if (a == 8'h81) v = {1'b0, m_ps[2:0], 1'b0, m_ie, m_rep, m_ena};
      if (a == 8'h82) v = {6'b0, m_ena, m_tout};
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin : mdl
    bit w_tr, w_tc, r_ts, tk, to, n_ena, n_tout;
    int n_cnt, n_phase;
    if (!rst) begin
      m_limit <= 0; m_cnt <= 0; m_ps <= 0; m_phase <= 0;
      m_ena <= 1'b0; m_rep <= 1'b0; m_ie <= 1'b0; m_tout <= 1'b0;
    end else begin
      w_tr = wr && addr == 8'h80;
      w_tc = wr && addr == 8'h81;
      r_ts = rd && !wr && addr == 8'h82;
      tk = m_ena && ((m_phase + 1) % div_of(m_ps) == 0) && !w_tr && !w_tc;
      to = tk && (m_cnt == 0);
      n_cnt = m_cnt; n_ena = m_ena; n_tout = m_tout;
      n_phase = m_ena ? m_phase + 1 : m_phase;
      if (r_ts) n_tout = 1'b0;
      if (to) begin
        n_tout = 1'b1;
        if (m_rep) n_cnt = m_limit; else n_ena = 1'b0;
      end else if (tk) begin
        n_cnt = m_cnt - 1;
      end
      if (w_tr) begin
        m_limit <= int'(wdat); n_cnt = int'(wdat); n_tout = 1'b0; n_phase = 0;
      end
      if (w_tc) begin
        n_ena = wdat[0]; m_rep <= wdat[1]; m_ie <= wdat[2];
        m_ps <= int'(wdat[6:4]); n_phase = 0;
      end
      m_cnt <= n_cnt; m_ena <= n_ena; m_tout <= n_tout; m_phase <= n_phase;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    chk("irq_vs_model", 32'(irq), 32'(m_tout & m_ie));
    chk("rdata_vs_model", 32'(rdat), 32'(mdl_rd(addr, rd)));
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdat = d; wr = 1'b1;
    @(posedge clk); #2;
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    addr = a; rd = 1'b1;
    #2 d = rdat;
    @(posedge clk); #2;
    rd = 1'b0;
    chk(name, 32'(d), 32'(exp));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) idle(1);
  endtask

  task automatic wait_irq(output int t);
    int n;
    n = 0;
    while (!irq && n < 400) begin idle(1); n++; end
    t = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t3;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = 8'h00; wdat = 8'h00;
    repeat (12) begin
      @(posedge clk); #2;
      addr = 8'(8'h7E + $urandom_range(0, 6));
      wdat = 8'($urandom);
      wr   = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
    end
    chk("reset_irq", 32'(irq), 32'h0);
    wr = 1'b0; rd = 1'b0; addr = 8'h00;
    idle(1);
    rst = 1'b1;
    idle(2);
    rd_chk("reset_tr", 8'h80, 8'h00);
    rd_chk("reset_tc", 8'h81, 8'h00);
    rd_chk("reset_ts", 8'h82, 8'h00);

    // One-shot, PS=0, LIMIT=3: timeout four edges after enabling.
    bus_wr(8'h80, 8'h03);
    bus_wr(8'h81, 8'h05);
    idle(3);
    chk("oneshot_irq_early", 32'(irq), 32'h0);
    idle(1);
    chk("oneshot_irq_at4", 32'(irq), 32'h1);
    rd_chk("oneshot_tc_after", 8'h81, 8'h04);
    rd_chk("oneshot_cnt_after", 8'h80, 8'h00);
    rd_chk("oneshot_ts_read", 8'h82, 8'h01);
    chk("oneshot_irq_cleared", 32'(irq), 32'h0);
    rd_chk("oneshot_ts_again", 8'h82, 8'h00);

    // Periodic, PS=1, LIMIT=2: period 48 cycles.
    bus_wr(8'h80, 8'h02);
    bus_wr(8'h81, 8'h17);
    t0 = cyc;
    rd_chk("periodic_tc", 8'h81, 8'h17);
    wait_irq(t1);
    chk("periodic_first_period", 32'(t1 - t0), 32'd48);
    rd_chk("periodic_ts_read", 8'h82, 8'h03);
    chk("periodic_irq_cleared", 32'(irq), 32'h0);
    // TS read landing on the timeout edge sees the old flag; the set survives.
    wait_cyc(t1 + 47);
    rd_chk("collide_ts_read", 8'h82, 8'h02);
    chk("collide_irq_kept", 32'(irq), 32'h1);
    rd_chk("collide_ts_after", 8'h82, 8'h03);
    wait_irq(t3);
    chk("periodic_third_timeout", 32'(t3 - t0), 32'd144);
    // TR write on a tick edge loads without decrementing.
    wait_cyc(t0 + 159);
    bus_wr(8'h80, 8'h05);
    rd_chk("tr_on_tick", 8'h80, 8'h05);
    // TC write disabling on a tick edge blocks the decrement.
    wait_cyc(t0 + 175);
    bus_wr(8'h81, 8'h16);
    rd_chk("tc_on_tick_cnt", 8'h80, 8'h05);
    rd_chk("tc_on_tick_ts", 8'h82, 8'h00);

    // Address decode.
    bus_wr(8'h83, 8'hFF);
    bus_wr(8'h7F, 8'hFF);
    bus_wr(8'h00, 8'h77);
    bus_wr(8'h41, 8'hFF);
    bus_wr(8'hC1, 8'hFF);
    rd_chk("decode_tr", 8'h80, 8'h05);
    rd_chk("decode_tc", 8'h81, 8'h16);
    rd_chk("decode_ts", 8'h82, 8'h00);
    rd_chk("decode_rsv", 8'h83, 8'h00);
    rd_chk("decode_out_84", 8'h84, 8'h00);
    addr = 8'h81; rd = 1'b0;
    #2 chk("decode_no_rd", 32'(rdat), 32'h0);
    idle(1);

    // Reset in the middle of a PS=7 count.
    bus_wr(8'h80, 8'h01);
    bus_wr(8'h81, 8'h75);
    idle(300);
    rd_chk("midcount_tr", 8'h80, 8'h01);
    rd_chk("midcount_tc", 8'h81, 8'h75);
    addr = 8'h81; rd = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_reset_tc", 32'(rdat), 32'h0);
    chk("async_reset_irq", 32'(irq), 32'h0);
    idle(2);
    rd = 1'b0;
    rst = 1'b1;
    idle(1);
    rd_chk("post_reset_tr", 8'h80, 8'h00);
    rd_chk("post_reset_tc", 8'h81, 8'h00);
    rd_chk("post_reset_ts", 8'h82, 8'h00);
    idle(20);
    chk("post_reset_irq", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
